commit_trace_arbiter: RTL and testbench
=======================================

COMMIT_TRACE_ARBITER -- requirements
Module: commit_trace_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, range 4..64.
REQ-002 SHALL have parameter CNT_W, default 16, meaning drop counter width.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable_i, input, 1, trace capture enable.
REQ-006 SHALL have port commit_valid_i, input, 2, per-port commit event strobe.
REQ-007 SHALL have port commit_pc_i, input, 2 x riscv::VLEN, committed PC per port.
REQ-008 SHALL have port commit_instr_i, input, 2 x 32, instruction word per port.
REQ-009 SHALL have port commit_rd_i, input, 2 x 5, destination register per port.
REQ-010 SHALL have port commit_wdata_i, input, 2 x 64, writeback data per port.
REQ-011 SHALL have port priv_lvl_i, input, riscv::priv_lvl_t, current privilege.
REQ-012 SHALL have port debug_mode_i, input, 1, core in debug mode.
REQ-013 SHALL have port ex_valid_i, ex_cause_i (64), ex_tval_i (64), all inputs, committed exception.
REQ-014 SHALL have port trace_valid_o, output, 1, head packet valid.
REQ-015 SHALL have port trace_ready_i, input, 1, sink accepts head.
REQ-016 SHALL have port trace_pkt_o, output, trace_pkt_t, head packet.
REQ-017 SHALL have port drop_cnt_o, output, CNT_W, dropped-event count.
REQ-018 SHALL have port overflow_o, output, 1, sticky drop flag.
REQ-019 SHALL have port busy_o, output, 1, high in RUN or DRAIN.

Function
REQ-020 SHALL implement FSM DISABLED, RUN, DRAIN: DISABLED->RUN on enable_i; RUN->DRAIN on !enable_i; DRAIN->RUN on enable_i; DRAIN->DISABLED when FIFO empty and !enable_i.
REQ-021 SHALL capture events only in RUN; events in DISABLED/DRAIN are discarded and not counted.
REQ-022 SHALL suppress an exception event when debug_mode_i=1 and ex_cause_i=riscv::BREAKPOINT.
REQ-023 SHALL order same-cycle events commit port 0, commit port 1, exception, in FIFO order.
REQ-024 SHALL enqueue all N (0..3) same-cycle events only if free slots >= N, free computed from count at cycle start (same-cycle pop gives no space).
REQ-025 SHALL otherwise drop all N events, add N to drop_cnt_o saturating at 2^CNT_W-1, and set overflow_o.
REQ-026 SHALL keep a 64-bit free-running cycle counter, 0 after reset, +1 per cycle, wrapping; each packet carries its capture-cycle value.
REQ-027 SHALL fill exception packets with pc=commit_pc_i[0], wdata=ex_cause_i, instr=ex_tval_i[31:0], rd=0.
REQ-028 SHALL assert trace_valid_o iff FIFO non-empty, driving the head registered, with no combinational path from trace_ready_i to trace_valid_o or trace_pkt_o.
REQ-029 SHALL pop the head on trace_valid_o && trace_ready_i; trace_pkt_o held stable while valid and not ready.
REQ-030 SHALL present an event captured in cycle N to an empty FIFO on trace_pkt_o in cycle N+1.
REQ-031 SHALL wrap read/write pointers modulo DEPTH; count width $clog2(DEPTH)+1.

Reset
REQ-032 SHALL on rst_ni=0 asynchronously force state DISABLED, FIFO empty, trace_valid_o=0, drop_cnt_o=0, overflow_o=0, busy_o=0, cycle counter 0; in-flight packets lost.
REQ-033 SHALL clear overflow_o and drop_cnt_o only by reset.

Structure
REQ-034 SHALL take trace_pkt_t (kind, pc, instr, rd, wdata, priv, timestamp) and trace_kind_e (TRACE_COMMIT, TRACE_EXCEPTION) from ariane_pkg.
REQ-035 SHALL place storage in one sub-module trace_fifo_mp: 3 write ports, 1 read port, all-or-nothing write.

Verification
REQ-036 SHALL test: enable=1, commit_valid_i=2'b11 with pcs 0x100/0x104, ready=1 -> next cycle pkt pc 0x100, then pc 0x104, timestamps equal.
REQ-037 SHALL test: DEPTH=8, ready=0, 7 single commits then 2'b11 plus exception -> 3 dropped, drop_cnt_o=3, overflow_o=1, count 7.
REQ-038 SHALL test: debug_mode_i=1, ex_cause_i=3 -> nothing enqueued; debug_mode_i=0 -> exception packet with wdata=3.
REQ-039 SHALL test: 5 queued, enable_i->0 -> busy_o high until 5 popped, new commits not counted, then DISABLED.
REQ-040 SHALL test: CNT_W=4, drop 20 events -> drop_cnt_o saturates at 15.
REQ-041 SHALL test: rst_ni low mid-drain with 3 queued -> trace_valid_o=0 immediately, all counters 0.

Source files
------------

// File: rtl/commit_trace_arbiter_pkg.sv
// rtl/commit_trace_arbiter_pkg.sv - shared types and constants for the commit trace arbiter
package commit_trace_arbiter_pkg;

   localparam int VLEN = 64;

   localparam logic [63:0] BREAKPOINT = 64'd3;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

   typedef enum logic {
      TRACE_COMMIT    = 1'b0,
      TRACE_EXCEPTION = 1'b1
   } trace_kind_e;

   typedef struct packed {
      trace_kind_e       kind;
      logic [VLEN-1:0]   pc;
      logic [31:0]       instr;
      logic [4:0]        rd;
      logic [63:0]       wdata;
      priv_lvl_t         priv;
      logic [63:0]       timestamp;
   } trace_pkt_t;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_RUN      = 2'd1,
      ST_DRAIN    = 2'd2
   } arb_state_e;

endpackage

// File: rtl/commit_trace_arbiter_trace_fifo_mp.sv
// rtl/commit_trace_arbiter_trace_fifo_mp.sv - 3-write/1-read trace FIFO with all-or-nothing writes
module trace_fifo_mp
   import commit_trace_arbiter_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [2:0]       wr_valid_i,
   input  trace_pkt_t [2:0] wr_pkt_i,
   output logic             wr_accept_o,
   output logic [1:0]       wr_num_o,
   input  logic             rd_en_i,
   output logic             empty_o,
   output trace_pkt_t       rd_data_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   free;
   logic [AW-1:0] wr_addr [3];
   logic          pop;
   trace_pkt_t    mem_q [DEPTH];

   // Slot offsets pack valid write ports contiguously in port order; space
   // is judged from the count at cycle start, so a same-cycle pop never helps.
   always_comb begin
      wr_num_o    = {1'b0, wr_valid_i[0]} + {1'b0, wr_valid_i[1]} + {1'b0, wr_valid_i[2]};
      free        = (AW+1)'(DEPTH) - count_q;
      wr_accept_o = (wr_num_o != 2'd0) && (free >= (AW+1)'(wr_num_o));
      wr_addr[0]  = wr_ptr_q;
      wr_addr[1]  = wr_ptr_q + AW'(wr_valid_i[0]);
      wr_addr[2]  = wr_ptr_q + AW'(wr_valid_i[0]) + AW'(wr_valid_i[1]);
      pop         = rd_en_i && (count_q != '0);
   end

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk_i) begin
      if (wr_accept_o) begin
         for (int p = 0; p < 3; p++) begin
            if (wr_valid_i[p]) begin
               mem_q[wr_addr[p]] <= wr_pkt_i[p];
            end
         end
      end
   end

   // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_accept_o) begin
            wr_ptr_q <= wr_ptr_q + AW'(wr_num_o);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + (wr_accept_o ? (AW+1)'(wr_num_o) : '0) - (AW+1)'(pop);
      end
   end

   assign empty_o   = (count_q == '0);
   assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/commit_trace_arbiter.sv
// rtl/commit_trace_arbiter.sv - captures commit/exception events into a trace packet stream
module commit_trace_arbiter
   import commit_trace_arbiter_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic [1:0]            commit_valid_i,
   input  logic [1:0][VLEN-1:0]  commit_pc_i,
   input  logic [1:0][31:0]      commit_instr_i,
   input  logic [1:0][4:0]       commit_rd_i,
   input  logic [1:0][63:0]      commit_wdata_i,
   input  priv_lvl_t             priv_lvl_i,
   input  logic                  debug_mode_i,
   input  logic                  ex_valid_i,
   input  logic [63:0]           ex_cause_i,
   input  logic [63:0]           ex_tval_i,
   output logic                  trace_valid_o,
   input  logic                  trace_ready_i,
   output trace_pkt_t            trace_pkt_o,
   output logic [CNT_W-1:0]      drop_cnt_o,
   output logic                  overflow_o,
   output logic                  busy_o
);

   arb_state_e       state_q;
   logic             busy_q;
   logic [63:0]      cyc_q;
   logic [CNT_W-1:0] drop_q;
   logic             ovf_q;

   logic             run;
   logic             ex_take;
   logic [2:0]       ev_valid;
   trace_pkt_t [2:0] ev_pkt;
   logic             wr_accept;
   logic [1:0]       wr_num;
   logic             fifo_empty;
   logic [CNT_W:0]   drop_sum;
   logic [CNT_W-1:0] drop_sat;
   logic             unused_tval;

   // Build the three candidate packets; breakpoints taken in debug mode are
   // the debugger's own traps and are not traced.
   always_comb begin
      run      = (state_q == ST_RUN);
      ex_take  = ex_valid_i && !(debug_mode_i && (ex_cause_i == BREAKPOINT));
      ev_valid = {ex_take, commit_valid_i} & {3{run}};
      ev_pkt   = '0;
      for (int p = 0; p < 2; p++) begin
         ev_pkt[p].kind      = TRACE_COMMIT;
         ev_pkt[p].pc        = commit_pc_i[p];
         ev_pkt[p].instr     = commit_instr_i[p];
         ev_pkt[p].rd        = commit_rd_i[p];
         ev_pkt[p].wdata     = commit_wdata_i[p];
         ev_pkt[p].priv      = priv_lvl_i;
         ev_pkt[p].timestamp = cyc_q;
      end
      ev_pkt[2].kind      = TRACE_EXCEPTION;
      ev_pkt[2].pc        = commit_pc_i[0];
      ev_pkt[2].instr     = ex_tval_i[31:0];
      ev_pkt[2].rd        = 5'd0;
      ev_pkt[2].wdata     = ex_cause_i;
      ev_pkt[2].priv      = priv_lvl_i;
      ev_pkt[2].timestamp = cyc_q;
      drop_sum = {1'b0, drop_q} + (CNT_W+1)'(wr_num);
      drop_sat = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
   end

   assign unused_tval = ^ex_tval_i[63:32];

   trace_fifo_mp #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr_valid_i  (ev_valid),
      .wr_pkt_i    (ev_pkt),
      .wr_accept_o (wr_accept),
      .wr_num_o    (wr_num),
      .rd_en_i     (trace_ready_i),
      .empty_o     (fifo_empty),
      .rd_data_o   (trace_pkt_o)
   );

   // Capture state machine with registered busy flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_DISABLED;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_DISABLED: begin
               if (enable_i) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!enable_i) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (enable_i) begin
                  state_q <= ST_RUN;
               end else if (fifo_empty) begin
                  state_q <= ST_DISABLED;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_DISABLED;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Free-running timestamp source.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_q + 64'd1;
      end
   end

   // Saturating drop counter and sticky overflow, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else if (run && (wr_num != 2'd0) && !wr_accept) begin
         drop_q <= drop_sat;
         ovf_q  <= 1'b1;
      end
   end

   assign trace_valid_o = !fifo_empty;
   assign drop_cnt_o    = drop_q;
   assign overflow_o    = ovf_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_commit_trace_arbiter.sv
// tb/tb_commit_trace_arbiter.sv - self-checking bench for commit_trace_arbiter
module tb_commit_trace_arbiter;
   import commit_trace_arbiter_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             enable;
   logic [1:0]       cv;
   logic [1:0][63:0] cpc;
   logic [1:0][31:0] cinstr;
   logic [1:0][4:0]  crd;
   logic [1:0][63:0] cwdata;
   priv_lvl_t        priv;
   logic             dbg;
   logic             exv;
   logic [63:0]      cause;
   logic [63:0]      tval;
   logic             tvalid;
   logic             tready;
   trace_pkt_t       pkt;
   logic [CNT_W-1:0] drop;
   logic             ovf;
   logic             busy;

   int               nchk;
   int               nerr;
   logic [63:0]      cyc;

   commit_trace_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .enable_i       (enable),
      .commit_valid_i (cv),
      .commit_pc_i    (cpc),
      .commit_instr_i (cinstr),
      .commit_rd_i    (crd),
      .commit_wdata_i (cwdata),
      .priv_lvl_i     (priv),
      .debug_mode_i   (dbg),
      .ex_valid_i     (exv),
      .ex_cause_i     (cause),
      .ex_tval_i      (tval),
      .trace_valid_o  (tvalid),
      .trace_ready_i  (tready),
      .trace_pkt_o    (pkt),
      .drop_cnt_o     (drop),
      .overflow_o     (ovf),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference cycle counter for timestamp expectations.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 64'd0;
      else        cyc <= cyc + 64'd1;
   end

   typedef struct {
      string       name;
      logic [1:0]  cv;
      logic        exv;
      logic        dbg;
      logic [63:0] cause;
      int          exp_n;
   } vec_t;

   typedef struct {
      logic        kind;
      logic [63:0] pc;
      logic [63:0] wdata;
      logic [31:0] instr;
      logic [4:0]  rd;
   } exp_t;

   vec_t vecs [8];
   exp_t expq [$];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_ports(input int i);
      cpc[0]    = 64'h1000 + 64'(i) * 64'd64;
      cpc[1]    = 64'h1000 + 64'(i) * 64'd64 + 64'd4;
      cinstr[0] = 32'h0000_0013 | (32'(i) << 8);
      cinstr[1] = 32'h0000_0093 | (32'(i) << 8);
      crd[0]    = 5'(i + 1);
      crd[1]    = 5'(i + 10);
      cwdata[0] = 64'hA000 + 64'(i);
      cwdata[1] = 64'hB000 + 64'(i);
      tval      = 64'hFEED_0000_0000_4000 + 64'(i);
   endtask

   task automatic clear_ev();
      cv    = 2'b00;
      exv   = 1'b0;
      dbg   = 1'b0;
      cause = 64'd0;
   endtask

   task automatic drain(output int n);
      tready = 1'b1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (!tvalid) break;
         n++;
         tick();
      end
      tready = 1'b0;
   endtask

   initial begin
      int         n;
      logic [63:0] ts;
      logic       busy_ok;

      nchk = 0;
      nerr = 0;
      rst_n = 1'b0;
      enable = 1'b0;
      tready = 1'b0;
      priv = PRIV_LVL_S;
      clear_ev();
      set_ports(0);

      vecs[0] = '{"v_p0",        2'b01, 1'b0, 1'b0, 64'd0, 1};
      vecs[1] = '{"v_p1",        2'b10, 1'b0, 1'b0, 64'd0, 1};
      vecs[2] = '{"v_ex3",       2'b00, 1'b1, 1'b0, 64'd3, 1};
      vecs[3] = '{"v_dbg_bkpt",  2'b00, 1'b1, 1'b1, 64'd3, 0};
      vecs[4] = '{"v_dbg_cause2",2'b00, 1'b1, 1'b1, 64'd2, 1};
      vecs[5] = '{"v_all3",      2'b11, 1'b1, 1'b0, 64'd5, 3};
      vecs[6] = '{"v_both_bkpt", 2'b11, 1'b1, 1'b1, 64'd3, 2};
      vecs[7] = '{"v_none",      2'b00, 1'b0, 1'b0, 64'd0, 0};

      // Reset state
      tick();
      tick();
      chk("rst_valid", 64'(tvalid), 64'd0);
      chk("rst_drop",  64'(drop),   64'd0);
      chk("rst_ovf",   64'(ovf),    64'd0);
      chk("rst_busy",  64'(busy),   64'd0);
      rst_n = 1'b1;

      // Dual commit ordering and shared timestamp
      enable = 1'b1;
      tick();
      chk("en_busy", 64'(busy), 64'd1);
      cv = 2'b11;
      cpc[0] = 64'h100;
      cpc[1] = 64'h104;
      tready = 1'b1;
      ts = cyc;
      tick();
      clear_ev();
      chk("dual_valid0", 64'(tvalid), 64'd1);
      chk("dual_pc0", pkt.pc, 64'h100);
      chk("dual_ts0", pkt.timestamp, ts);
      tick();
      chk("dual_valid1", 64'(tvalid), 64'd1);
      chk("dual_pc1", pkt.pc, 64'h104);
      chk("dual_ts1", pkt.timestamp, ts);
      tick();
      chk("dual_empty", 64'(tvalid), 64'd0);
      tready = 1'b0;

      // Table-driven single-cycle event patterns
      for (int i = 0; i < 8; i++) begin
         set_ports(i);
         cv = vecs[i].cv;
         exv = vecs[i].exv;
         dbg = vecs[i].dbg;
         cause = vecs[i].cause;
         expq.delete();
         if (cv[0]) expq.push_back('{1'b0, cpc[0], cwdata[0], cinstr[0], crd[0]});
         if (cv[1]) expq.push_back('{1'b0, cpc[1], cwdata[1], cinstr[1], crd[1]});
         if (exv && !(dbg && cause == 64'd3))
            expq.push_back('{1'b1, cpc[0], cause, tval[31:0], 5'd0});
         tick();
         clear_ev();
         tready = 1'b1;
         for (int k = 0; k < vecs[i].exp_n; k++) begin
            chk($sformatf("%s_valid%0d", vecs[i].name, k), 64'(tvalid), 64'd1);
            if (k < expq.size()) begin
               chk($sformatf("%s_kind%0d", vecs[i].name, k), 64'(pkt.kind), 64'(expq[k].kind));
               chk($sformatf("%s_pc%0d", vecs[i].name, k), pkt.pc, expq[k].pc);
               chk($sformatf("%s_wdata%0d", vecs[i].name, k), pkt.wdata, expq[k].wdata);
               chk($sformatf("%s_instr%0d", vecs[i].name, k), 64'(pkt.instr), 64'(expq[k].instr));
               chk($sformatf("%s_rd%0d", vecs[i].name, k), 64'(pkt.rd), 64'(expq[k].rd));
               chk($sformatf("%s_priv%0d", vecs[i].name, k), 64'(pkt.priv), 64'(PRIV_LVL_S));
            end
            tick();
         end
         chk($sformatf("%s_empty", vecs[i].name), 64'(tvalid), 64'd0);
         tready = 1'b0;
      end

      // Drain: 5 queued, disable, late commits ignored, then DISABLED
      for (int k = 0; k < 5; k++) begin
         set_ports(20 + k);
         cv = 2'b01;
         tick();
      end
      clear_ev();
      enable = 1'b0;
      tick();
      chk("drn_busy", 64'(busy), 64'd1);
      set_ports(30);
      cv = 2'b11;
      tick();
      clear_ev();
      chk("drn_head_pc", pkt.pc, 64'h1000 + 64'd20 * 64'd64);
      tready = 1'b1;
      n = 0;
      busy_ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (!tvalid) break;
         if (!busy) busy_ok = 1'b0;
         n++;
         tick();
      end
      tready = 1'b0;
      chk("drn_busy_held", 64'(busy_ok), 64'd1);
      chk("drn_pops", 64'(n), 64'd5);
      tick();
      chk("drn_disabled", 64'(busy), 64'd0);
      chk("drn_drop", 64'(drop), 64'd0);
      chk("drn_ovf", 64'(ovf), 64'd0);
      cv = 2'b01;
      tick();
      clear_ev();
      chk("dis_no_capture", 64'(tvalid), 64'd0);
      enable = 1'b1;
      tick();

      // Overflow: 7 singles then 3 events with one free slot
      for (int k = 0; k < 7; k++) begin
         set_ports(40 + k);
         cv = 2'b01;
         tick();
      end
      cv = 2'b11;
      exv = 1'b1;
      cause = 64'd7;
      tick();
      clear_ev();
      chk("ovf_drop3", 64'(drop), 64'd3);
      chk("ovf_flag", 64'(ovf), 64'd1);
      drain(n);
      chk("ovf_count7", 64'(n), 64'd7);

      // Saturation at 2^CNT_W-1
      for (int k = 0; k < 8; k++) begin
         cv = 2'b01;
         tick();
      end
      cv = 2'b11;
      exv = 1'b1;
      cause = 64'd7;
      tick();
      chk("sat_drop6", 64'(drop), 64'd6);
      for (int k = 0; k < 4; k++) tick();
      cv = 2'b01;
      exv = 1'b0;
      tick();
      clear_ev();
      chk("sat_drop15", 64'(drop), 64'd15);
      chk("sat_ovf", 64'(ovf), 64'd1);
      drain(n);
      chk("sat_count8", 64'(n), 64'd8);

      // Reset in the middle of a drain
      for (int k = 0; k < 3; k++) begin
         cv = 2'b01;
         tick();
      end
      clear_ev();
      enable = 1'b0;
      tick();
      chk("mid_pre_valid", 64'(tvalid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_valid", 64'(tvalid), 64'd0);
      chk("mid_drop", 64'(drop), 64'd0);
      chk("mid_ovf", 64'(ovf), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      tick();
      rst_n = 1'b1;
      enable = 1'b1;
      tick();
      tick();
      set_ports(60);
      cv = 2'b01;
      ts = cyc;
      tick();
      clear_ev();
      chk("post_ts", pkt.timestamp, ts);
      chk("post_ts_small", 64'(pkt.timestamp == 64'd2), 64'd1);
      drain(n);
      chk("post_count1", 64'(n), 64'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
